contador_ocupacao_elevador_param: RTL
=====================================

Name: contador_ocupacao_elevador_param

Overview:
- Parametrised occupancy counter for the elevator cabin; successor of the fixed 2-bit, capacity-3 people counter.
- Counts entries (botao_subir) and exits (botao_descer) on rising edges only, saturates at 0 and CAPACIDADE, and flags full/empty.
- Raises a timed overload alert when someone tries to enter a full cabin.
- Sits between the cabin push-buttons and the elevator control/LED logic.

Parameters:
- CAPACIDADE, 3, maximum number of people allowed in the cabin (>=1).
- LARGURA, 2, width of the count output; must satisfy 2**LARGURA-1 >= CAPACIDADE.
- ALERTA_CICLOS, 4, number of clock cycles alerta stays high after a rejected entry (>=1).

Ports:
- clock  input  1  system clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- botao_subir  input  1  entry button, level; one entry per rising edge.
- botao_descer  input  1  exit button, level; one exit per rising edge.
- quantidade_pessoas  output  LARGURA  registered current occupancy.
- cheio  output  1  registered, high when quantidade_pessoas == CAPACIDADE.
- vazio  output  1  registered, high when quantidade_pessoas == 0.
- alerta  output  1  registered overload alert.

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: quantidade_pessoas=0, vazio=1, cheio=0, alerta=0, alert counter=0, button history registers=0.
- Edge detection:
  - ant_subir and ant_descer register the previous button levels.
  - sobe = botao_subir & ~ant_subir; desce = botao_descer & ~ant_descer.
  - A held button counts once. The first sample after reset with a button already high counts as an edge.
- Latency: count, cheio and vazio reflect an event at the same rising edge where the edge is sampled, i.e. 1 cycle after the input rises.
- Next count, priority order:
  - sobe & desce together: no change, no alert (one in, one out).
  - sobe & count<CAPACIDADE: count+1.
  - sobe & count==CAPACIDADE: no change; rejected entry.
  - desce & count>0: count-1.
  - desce & count==0: no change, no alert; underflow is silently ignored.
  - otherwise: hold.
- Arithmetic is in LARGURA bits. Saturation guarantees no wrap-around.
- cheio and vazio are computed from the next count, so they are coherent with quantidade_pessoas in the same cycle.
- Alert counter (width clog2(ALERTA_CICLOS+1)):
  - A rejected entry loads it with ALERTA_CICLOS. Otherwise it decrements while nonzero.
  - alerta is high while the counter is nonzero, i.e. exactly ALERTA_CICLOS cycles starting 1 cycle after the rejected edge.
  - A new rejected entry during the alert reloads the counter (retrigger).
  - A valid desce does not clear a running timed alert.
- Reset mid-operation: on the next edge, count, flags, alert and edge history return to reset values. An edge present during reset is discarded.

Optional Feature:
- Macro: ALERTA_TRAVADO_EN.
- Defined:
  - alerta is latched: set by a rejected entry and held until the first valid exit (desce with count>0, not simultaneous with sobe) or reset.
  - ALERTA_CICLOS is unused.
  - alerta clears on the same edge the count decrements.
- Not defined: timed, retriggerable alert as described in Behaviour.

Test Plan (CAPACIDADE=3, LARGURA=2, ALERTA_CICLOS=4):
- Reset, then 3 separate botao_subir pulses -> quantidade_pessoas 1,2,3; cheio=1 after the third pulse, vazio=0 after the first; alerta stays 0.
- Hold botao_subir high 10 cycles from count 0 -> count=1 only, held constant for the remaining cycles.
- At count 3, one botao_subir pulse -> count stays 3; alerta=1 for exactly 4 cycles. A second pulse on alert cycle 2 -> alerta extends to 4 cycles from the second pulse. With ALERTA_TRAVADO_EN: alerta stays 1 until a botao_descer pulse, then count=2 and alerta=0 on the same edge.
- At count 0, botao_descer pulses -> count stays 0, vazio=1, alerta=0. At count 2, both buttons rise in the same cycle -> count stays 2.
- At count 2 with alerta active, assert reset for 1 cycle while botao_subir rises -> count=0, vazio=1, cheio=0, alerta=0 after the edge; the entry is not counted.

Source files
------------

// File: rtl/contador_ocupacao_elevador_param.sv
// contador_ocupacao_elevador_param: saturating cabin occupancy counter with full/empty flags and overload alert
// Optional macro ALERTA_TRAVADO_EN: alert latches until the first valid exit instead of timing out.
module contador_ocupacao_elevador_param #(
    parameter int CAPACIDADE    = 3,
    parameter int LARGURA       = 2,
    parameter int ALERTA_CICLOS = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               botao_subir,
    input  logic               botao_descer,
    output logic [LARGURA-1:0] quantidade_pessoas,
    output logic               cheio,
    output logic               vazio,
    output logic               alerta
);
    localparam logic [LARGURA-1:0] CAP = LARGURA'(CAPACIDADE);
    logic               ant_subir_q, ant_descer_q;
    logic               sobe, desce, rejeita, saida_valida;
    logic [LARGURA-1:0] cont_q, cont_d;
    logic               cheio_q, vazio_q, alerta_q;
    assign sobe  = botao_subir & ~ant_subir_q;
    assign desce = botao_descer & ~ant_descer_q;
    assign quantidade_pessoas = cont_q;
    assign cheio  = cheio_q;
    assign vazio  = vazio_q;
    assign alerta = alerta_q;
    // next occupancy: simultaneous in/out cancels, entries saturate at capacity, exits at zero
    always_comb begin
        cont_d       = cont_q;
        rejeita      = 1'b0;
        saida_valida = 1'b0;
        if (sobe && !desce) begin
            if (cont_q < CAP) cont_d = cont_q + 1'b1;
            else              rejeita = 1'b1;
        end else if (desce && !sobe && cont_q != '0) begin
            cont_d       = cont_q - 1'b1;
            saida_valida = 1'b1;
        end
    end
    // count, flags derived from the next count, and button history
    always_ff @(posedge clock) begin
        if (reset) begin
            cont_q       <= '0;
            cheio_q      <= 1'b0;
            vazio_q      <= 1'b1;
            ant_subir_q  <= 1'b0;
            ant_descer_q <= 1'b0;
        end else begin
            cont_q       <= cont_d;
            cheio_q      <= cont_d == CAP;
            vazio_q      <= cont_d == '0;
            ant_subir_q  <= botao_subir;
            ant_descer_q <= botao_descer;
        end
    end
`ifdef ALERTA_TRAVADO_EN
    // latched alert: set on a rejected entry, cleared by the first valid exit
    always_ff @(posedge clock) begin
        if (reset) alerta_q <= 1'b0;
        else       alerta_q <= rejeita ? 1'b1 : (saida_valida ? 1'b0 : alerta_q);
    end
`else
    localparam int AW = $clog2(ALERTA_CICLOS + 1);
    logic [AW-1:0] alerta_cnt_q, alerta_cnt_d;
    assign alerta_cnt_d = rejeita ? AW'(ALERTA_CICLOS)
                        : (alerta_cnt_q != '0 ? alerta_cnt_q - 1'b1 : alerta_cnt_q);
    // timed, retriggerable alert; valid exits do not cut it short
    always_ff @(posedge clock) begin
        if (reset) begin
            alerta_cnt_q <= '0;
            alerta_q     <= 1'b0;
        end else begin
            alerta_cnt_q <= alerta_cnt_d;
            alerta_q     <= alerta_cnt_d != '0;
        end
    end
    logic unused_ok;
    assign unused_ok = saida_valida;
`endif
endmodule
